fabric_arbiter: RTL and testbench

Round-robin input arbiter that drives the one-hot `grant` vector consumed by `switch_fabric`. It sits between the eight input-port FIFOs and the fabric. Each cycle it picks at most one non-empty input whose head-of-line destination can accept a word. It pops the granted FIFO and counts words discarded for out-of-range destinations.

---
 rtl/fabric_arbiter.sv | 107 ++++++++++
 tb/tb_fabric_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_arbiter.sv
// -----------------------------------------------------------------------------
// fabric_arbiter
//
// Round-robin arbiter between the eight input-port FIFOs and switch_fabric.
// Each cycle it grants at most one non-empty input whose head-of-line
// destination can take a word. The granted FIFO pops at the end of the grant
// cycle. Words with an invalid destination (addr bit 3 set) are always
// grantable, are discarded downstream, and are counted in drop_cnt.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - req[i]=1 when input FIFO i is non-empty
//   addr     - head-of-line destination per FIFO; bit 3 set = invalid
//   full     - full[d]=1 when output queue d cannot accept a word
//   hold     - blocks new grants while high
//   grant    - registered one-hot (or zero) grant, drives switch_fabric.grant
//   pop      - copy of grant, pops the granted input FIFO
//   drop_cnt - saturating count of granted words with an invalid destination
// -----------------------------------------------------------------------------
module fabric_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  input  logic [3:0]       addr [7:0],
  input  logic [7:0]       full,
  input  logic             hold,
  output logic [7:0]       grant,
  output logic [7:0]       pop,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [2:0] ptr;
  logic [2:0] last_dst;
  logic       last_dst_v;

  logic [7:0] elig_p0;
  logic [7:0] inv_p0;
  logic       win_vld_p0;
  logic [2:0] win_idx_p0;
  logic [2:0] scan_idx_p0;
  logic       drop_hit_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: eligibility and round-robin selection from current-cycle inputs
  always_comb begin
    elig_p0 = '0;
    inv_p0  = '0;
    for (int i = 0; i < 8; i++) begin
      inv_p0[i] = addr[i][3];
      // A port being granted now is excluded: its FIFO head is stale until
      // the pop lands. The last_dst guard covers the one-push lag of full.
      elig_p0[i] = req[i] & ~grant[i] &
                   (addr[i][3] |
                    (~full[addr[i][2:0]] &
                     (~last_dst_v | (last_dst != addr[i][2:0]))));
    end
  end

  always_comb begin
    win_vld_p0  = 1'b0;
    win_idx_p0  = '0;
    scan_idx_p0 = '0;
    for (int k = 0; k < 8; k++) begin
      scan_idx_p0 = ptr + 3'(k);
      if (!win_vld_p0 && elig_p0[scan_idx_p0]) begin
        win_vld_p0 = 1'b1;
        win_idx_p0 = scan_idx_p0;
      end
    end
  end

  // The word granted in the current cycle is consumed at this edge.
  assign drop_hit_p0 = |(grant & inv_p0);

  // Stage p1: registered grant and arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      ptr        <= '0;
      last_dst   <= '0;
      last_dst_v <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (drop_hit_p0) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (!hold && win_vld_p0) begin
        grant      <= 8'b1 << win_idx_p0;
        ptr        <= win_idx_p0 + 3'd1;
        last_dst   <= addr[win_idx_p0][2:0];
        last_dst_v <= ~addr[win_idx_p0][3];
      end else begin
        grant      <= '0;
        last_dst_v <= 1'b0;
      end
    end
  end

  assign pop = grant;

endmodule

// File: tb/tb_fabric_arbiter.sv
module tb_fabric_arbiter;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [7:0]       req;
  logic [3:0]       addr [7:0];
  logic [7:0]       full;
  logic             hold;
  logic [7:0]       grant;
  logic [7:0]       pop;
  logic [CNT_W-1:0] drop_cnt;

  int checks;
  int errors;

  fabric_arbiter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .full     (full),
    .hold     (hold),
    .grant    (grant),
    .pop      (pop),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req  = '0;
    full = '0;
    hold = 1'b0;
    for (int i = 0; i < 8; i++) addr[i] = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < 8; i++) addr[i] = 4'(i);
    req = 8'hFF;
    rst = 1'b1;
    #2;
    checks++;
    if (grant !== 8'h00 || pop !== 8'h00) begin
      errors++;
      $display("FAIL reset_async grant=%h pop=%h expected 00", grant, pop);
    end
    step();
    step();
    checks++;
    if (grant !== 8'h00) begin
      errors++;
      $display("FAIL reset_grant grant=%h expected 00", grant);
    end
    checks++;
    if (drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset_drop drop_cnt=%0d expected 0", drop_cnt);
    end
    rst = 1'b0;
    req = 8'h00;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (grant !== 8'h00) begin
        errors++;
        $display("FAIL idle_grant cycle %0d grant=%h expected 00", n, grant);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    do_reset();
    for (int i = 0; i < 8; i++) addr[i] = 4'(i);
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      step();
      exp_g = 8'h01 << (n % 8);
      checks++;
      if (grant !== exp_g || pop !== exp_g) begin
        errors++;
        $display("FAIL round_robin cycle %0d grant=%h pop=%h expected %h",
                 n, grant, pop, exp_g);
      end
    end
  endtask

  task automatic test_same_port_gap();
    logic [7:0] exp_seq [0:4];
    exp_seq = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h08};
    do_reset();
    addr[3] = 4'd5;
    req     = 8'h08;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (grant !== exp_seq[n]) begin
        errors++;
        $display("FAIL same_port cycle %0d grant=%h expected %h",
                 n, grant, exp_seq[n]);
      end
    end
  endtask

  task automatic test_same_dst_gap();
    logic [7:0] exp_seq [0:5];
    exp_seq = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00};
    do_reset();
    addr[0] = 4'd2;
    addr[1] = 4'd2;
    req     = 8'h03;
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (grant !== exp_seq[n]) begin
        errors++;
        $display("FAIL same_dst cycle %0d grant=%h expected %h",
                 n, grant, exp_seq[n]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq [0:4];
    exp_seq = '{8'h40, 8'h00, 8'h04, 8'h40, 8'h04};
    do_reset();
    addr[2] = 4'd4;
    addr[6] = 4'd1;
    full    = 8'h10;
    req     = 8'h44;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (grant !== exp_seq[n]) begin
        errors++;
        $display("FAIL backpressure cycle %0d grant=%h expected %h",
                 n, grant, exp_seq[n]);
      end
      if (n == 1) full = 8'h00;
    end
  endtask

  task automatic test_invalid_addr();
    logic [7:0]       exp_g;
    logic [CNT_W-1:0] exp_c;
    do_reset();
    addr[5] = 4'b1000;
    full    = 8'hFF;
    req     = 8'h20;
    for (int n = 1; n <= 40; n++) begin
      step();
      exp_g = (n % 2 == 1) ? 8'h20 : 8'h00;
      exp_c = ((n / 2) > 15) ? 4'd15 : 4'(n / 2);
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL invalid_grant cycle %0d grant=%h expected %h",
                 n, grant, exp_g);
      end
      checks++;
      if (drop_cnt !== exp_c) begin
        errors++;
        $display("FAIL drop_cnt cycle %0d drop_cnt=%0d expected %0d",
                 n, drop_cnt, exp_c);
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [7:0] exp_pre [0:2];
    exp_pre = '{8'h01, 8'h02, 8'h04};
    do_reset();
    for (int i = 0; i < 8; i++) addr[i] = 4'(i);
    req = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (grant !== exp_pre[n]) begin
        errors++;
        $display("FAIL hold_pre cycle %0d grant=%h expected %h",
                 n, grant, exp_pre[n]);
      end
    end
    hold = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (grant !== 8'h00) begin
        errors++;
        $display("FAIL hold_active cycle %0d grant=%h expected 00", n, grant);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (grant !== 8'h08) begin
      errors++;
      $display("FAIL hold_resume grant=%h expected 08", grant);
    end
    step();
    checks++;
    if (grant !== 8'h10) begin
      errors++;
      $display("FAIL pre_reset grant=%h expected 10", grant);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00 || pop !== 8'h00) begin
      errors++;
      $display("FAIL midgrant_reset grant=%h pop=%h expected 00", grant, pop);
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 8'h01) begin
      errors++;
      $display("FAIL post_reset grant=%h expected 01", grant);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_same_port_gap();
    test_same_dst_gap();
    test_backpressure();
    test_invalid_addr();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
